// File: rtl/timer_counter.sv
// timer_counter: memory-mapped 32-bit countdown timer with one-shot and
// auto-reload modes. Registers: CTRL (addr[3:2]=0), PRESET (1), COUNT (2).
// Bus contract: single-cycle writes qualified by we (already decoded by the
// bridge) merged per byte through byteen; reads are combinational on addr
// with no handshake and no latency.
module timer_counter (
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [3:0]  byteen,
  output logic [31:0] rdata,
  output logic        irq,
  output logic [1:0]  state_dbg_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_CNT  = 2'd2,
    ST_INT  = 2'd3
  } state_e;

  localparam logic [1:0] SEL_CTRL   = 2'd0;
  localparam logic [1:0] SEL_PRESET = 2'd1;
  localparam logic [1:0] SEL_COUNT  = 2'd2;

  state_e      state_q, state_d;
  logic [3:0]  ctrl_q, ctrl_d;
  logic [31:0] preset_q, preset_d;
  logic [31:0] count_q, count_d;
  logic        irq_flag_q, irq_flag_d;

  logic        en;
  logic        auto_reload;
  logic [1:0]  sel;

  assign en          = ctrl_q[0];
  assign auto_reload = (ctrl_q[2:1] == 2'b01);
  assign sel         = addr[3:2];

  // Only addr[3:2] is decoded; the remaining address bits are intentionally ignored.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{addr[31:4], addr[1:0]};

  // State and register storage; reset aborts any count in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      ctrl_q     <= 4'd0;
      preset_q   <= 32'd0;
      count_q    <= 32'd0;
      irq_flag_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ctrl_q     <= ctrl_d;
      preset_q   <= preset_d;
      count_q    <= count_d;
      irq_flag_q <= irq_flag_d;
    end
  end

  // Next-state logic: FSM updates first, then CPU writes override CTRL so a
  // software write in the INT cycle beats the hardware EN clear.
  always_comb begin
    state_d    = state_q;
    ctrl_d     = ctrl_q;
    preset_d   = preset_q;
    count_d    = count_q;
    irq_flag_d = irq_flag_q;

    case (state_q)
      ST_IDLE: begin
        if (en) begin
          irq_flag_d = 1'b0;
          state_d    = ST_LOAD;
        end
      end
      ST_LOAD: begin
        count_d = preset_q;
        state_d = ST_CNT;
      end
      ST_CNT: begin
        if (!en) begin
          state_d = ST_IDLE;
        end else if (count_q > 32'd1) begin
          count_d = count_q - 32'd1;
        end else begin
          count_d    = 32'd0;
          irq_flag_d = 1'b1;
          state_d    = ST_INT;
        end
      end
      ST_INT: begin
        if (auto_reload) begin
          irq_flag_d = 1'b0;
        end else begin
          ctrl_d[0] = 1'b0;
        end
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (we) begin
      if (sel == SEL_CTRL && byteen[0]) begin
        ctrl_d = wdata[3:0];
      end
      if (sel == SEL_PRESET) begin
        for (int i = 0; i < 4; i++) begin
          if (byteen[i]) begin
            preset_d[8*i +: 8] = wdata[8*i +: 8];
          end
        end
      end
    end
  end

  // Combinational read mux; COUNT is read-only and the reserved slot reads 0.
  always_comb begin
    rdata = 32'd0;
    case (sel)
      SEL_CTRL:   rdata = {28'd0, ctrl_q};
      SEL_PRESET: rdata = preset_q;
      SEL_COUNT:  rdata = count_q;
      default:    rdata = 32'd0;
    endcase
  end

  assign irq         = ctrl_q[3] & irq_flag_q;
  assign state_dbg_o = state_q;

endmodule

// File: tb/tb_timer_counter.sv
// Directed bench for timer_counter with an expected-value queue.
module tb_timer_counter;

  logic        clk;
  logic        reset;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  byteen;
  logic [31:0] rdata;
  logic        irq;
  logic [1:0]  state_dbg_o;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_q[$];

  timer_counter dut (
    .clk         (clk),
    .reset       (reset),
    .we          (we),
    .addr        (addr),
    .wdata       (wdata),
    .byteen      (byteen),
    .rdata       (rdata),
    .irq         (irq),
    .state_dbg_o (state_dbg_o)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock edge, then settle past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Bus write that lands on the next rising edge.
  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
    addr   = a;
    wdata  = d;
    byteen = b;
    we     = 1'b1;
    @(posedge clk);
    #1;
    we = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    addr = a;
    #1;
    d = rdata;
  endtask

  task automatic expect_v(input logic [31:0] v);
    exp_q.push_back(v);
  endtask

  // Scoreboard compare: pops the oldest expectation.
  task automatic chk(input string tag, input logic [31:0] obs);
    logic [31:0] e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $error("FAIL %s: got %h but no expected value queued", tag, obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e) else begin
        errors++;
        $error("FAIL %s: got %h expected %h", tag, obs, e);
      end
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    we    = 1'b0;
    step();
    step();
    reset = 1'b1;
  endtask

  initial begin
    logic [31:0] d;
    int p;
    logic [31:0] cnt_tbl [6];
    cnt_tbl[0] = 32'd3; cnt_tbl[1] = 32'd2; cnt_tbl[2] = 32'd1;
    cnt_tbl[3] = 32'd0; cnt_tbl[4] = 32'd0; cnt_tbl[5] = 32'd0;

    reset  = 1'b0;
    we     = 1'b0;
    addr   = 32'd0;
    wdata  = 32'd0;
    byteen = 4'h0;

    // Reset state
    do_reset();
    rd(32'h0, d); expect_v(32'd0); chk("rst_ctrl", d);
    rd(32'h4, d); expect_v(32'd0); chk("rst_preset", d);
    rd(32'h8, d); expect_v(32'd0); chk("rst_count", d);
    expect_v(32'd0); chk("rst_irq", {31'd0, irq});
    expect_v(32'd0); chk("rst_state", {30'd0, state_dbg_o});

    // One-shot, PRESET=5, CTRL=0x9 written at edge 0
    wr(32'h4, 32'd5, 4'hF);
    wr(32'h0, 32'h9, 4'hF);
    addr = 32'h8;
    for (int e = 1; e <= 9; e++) begin
      step();
      if (e == 1) expect_v(32'd0);
      else if (e < 7) expect_v(32'(7 - e));
      else expect_v(32'd0);
      chk($sformatf("os_count_e%0d", e), rdata);
      expect_v((e >= 7) ? 32'd1 : 32'd0);
      chk($sformatf("os_irq_e%0d", e), {31'd0, irq});
    end
    rd(32'h0, d); expect_v(32'h8); chk("os_ctrl_after", d);

    // Collision: CTRL=0x9 written during the INT cycle
    do_reset();
    wr(32'h4, 32'd2, 4'hF);
    wr(32'h0, 32'h9, 4'hF);
    step(); step(); step(); step();
    expect_v(32'd3); chk("col_state_int", {30'd0, state_dbg_o});
    expect_v(32'd1); chk("col_irq_int", {31'd0, irq});
    wr(32'h0, 32'h9, 4'hF);
    expect_v(32'd0); chk("col_state_idle", {30'd0, state_dbg_o});
    rd(32'h0, d); expect_v(32'h9); chk("col_ctrl_en_kept", d);
    expect_v(32'd1); chk("col_irq_held", {31'd0, irq});
    step();
    expect_v(32'd1); chk("col_state_load", {30'd0, state_dbg_o});
    expect_v(32'd0); chk("col_irq_cleared", {31'd0, irq});
    step();
    rd(32'h8, d); expect_v(32'd2); chk("col_reload", d);

    // Byte enables, CTRL width, reserved slot
    do_reset();
    wr(32'h4, 32'hAABBCCDD, 4'hF);
    wr(32'h4, 32'h11223344, 4'h5);
    rd(32'h4, d); expect_v(32'hAA22CC44); chk("be_preset", d);
    wr(32'hC, 32'hDEADBEEF, 4'hF);
    rd(32'hC, d); expect_v(32'd0); chk("reserved_rd", d);
    wr(32'h0, 32'hFFFFFFFF, 4'hF);
    rd(32'h0, d); expect_v(32'hF); chk("ctrl_width", d);

    // Pause, COUNT write ignored, reload, masked expiry, unmask
    do_reset();
    wr(32'h4, 32'd10, 4'hF);
    wr(32'h0, 32'h1, 4'hF);
    step(); step(); step(); step();
    wr(32'h0, 32'h0, 4'hF);
    step();
    rd(32'h8, d); expect_v(32'd7); chk("pause_count", d);
    expect_v(32'd0); chk("pause_state", {30'd0, state_dbg_o});
    wr(32'h8, 32'h55, 4'hF);
    rd(32'h8, d); expect_v(32'd7); chk("count_ro", d);
    wr(32'h0, 32'h1, 4'hF);
    step(); step();
    rd(32'h8, d); expect_v(32'd10); chk("reenable_reload", d);
    for (int i = 0; i < 10; i++) step();
    expect_v(32'd3); chk("mask_state_int", {30'd0, state_dbg_o});
    expect_v(32'd0); chk("mask_irq_low", {31'd0, irq});
    step();
    rd(32'h0, d); expect_v(32'd0); chk("mask_en_cleared", d);
    expect_v(32'd0); chk("mask_irq_still_low", {31'd0, irq});
    wr(32'h0, 32'h8, 4'hF);
    expect_v(32'd1); chk("unmask_irq", {31'd0, irq});

    // Auto-reload, PRESET=3, CTRL=0xB written at edge 0
    do_reset();
    wr(32'h4, 32'd3, 4'hF);
    wr(32'h0, 32'hB, 4'hF);
    addr = 32'h8;
    for (int e = 1; e <= 18; e++) begin
      step();
      if (e == 1) begin
        expect_v(32'd0);
        p = -1;
      end else begin
        p = (e - 2) % 6;
        expect_v(cnt_tbl[p]);
      end
      chk($sformatf("ar_count_e%0d", e), rdata);
      expect_v((p == 3) ? 32'd1 : 32'd0);
      chk($sformatf("ar_irq_e%0d", e), {31'd0, irq});
    end

    // Asynchronous reset mid-count (COUNT=3 after edge 20)
    step(); step();
    rd(32'h8, d); expect_v(32'd3); chk("ar_before_reset", d);
    #2;
    reset = 1'b0;
    #1;
    expect_v(32'd0); chk("async_rst_count", rdata);
    expect_v(32'd0); chk("async_rst_irq", {31'd0, irq});
    expect_v(32'd0); chk("async_rst_state", {30'd0, state_dbg_o});
    rd(32'h0, d); expect_v(32'd0); chk("async_rst_ctrl", d);
    rd(32'h4, d); expect_v(32'd0); chk("async_rst_preset", d);
    step();
    reset = 1'b1;
    step();
    step();
    rd(32'h8, d); expect_v(32'd0); chk("after_rst_idle", d);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/timer_counter.md
# timer_counter

Memory-mapped countdown timer that sits downstream of the pipelined CPU core on its data bus. It consumes the core's M-stage store interface (address, write data, byte enables) after bridge decode, returns read data for loads, and drives one `HWInt` line back into the core. It supports one-shot and auto-reload modes through a four-state FSM.

## Interface
Parameters:
- None. Register width is fixed at 32 bits.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset. Low forces reset state immediately.
- `we`  in  1  write strobe, already gated by bridge address decode for this device.
- `addr`  in  32  byte address; only `addr[3:2]` is decoded.
  - 0 = CTRL
  - 1 = PRESET
  - 2 = COUNT
  - 3 = reserved
- `wdata`  in  32  write data, i.e. the core's `m_data_wdata`.
- `byteen`  in  4  byte write enables; bit i enables `wdata[8i+7:8i]`.
- `rdata`  out  32  combinational read of the register selected by `addr[3:2]`.
- `irq`  out  1  interrupt request to `HWInt[0]`; equals `CTRL.IM & irq_flag`.

## Operation
Registers:
- **CTRL**
  - bit0 EN (enable)
  - bits[2:1] MODE: 00 = one-shot, 01 = auto-reload, 1x = treated as one-shot
  - bit3 IM (interrupt mask)
  - bits[31:4] read as 0 and are not writable
- **PRESET**: 32-bit reload value, fully byte-writable.
- **COUNT**: 32-bit current count. Read-only; writes are ignored.
- **Reserved** (`addr[3:2]` = 3): reads 0, writes ignored.
- Byte merge: a written byte replaces the stored byte only where its `byteen` bit is 1.

FSM states: IDLE, LOAD, CNT, INT.
- **IDLE**: if EN=1, clear `irq_flag` and go to LOAD; otherwise stay.
- **LOAD**: COUNT <= PRESET; go to CNT.
- **CNT**:
  - EN=0: go to IDLE; COUNT holds its value.
  - EN=1 and COUNT>1: COUNT <= COUNT-1.
  - EN=1 and COUNT<=1: COUNT <= 0, `irq_flag` <= 1, go to INT.
- **INT**:
  - MODE one-shot: clear CTRL.EN; `irq_flag` holds.
  - MODE auto-reload: clear `irq_flag`.
  - In both modes, go to IDLE.

Priority and boundary rules:
- A CPU write to CTRL in the same cycle that INT clears EN: the CPU write wins.
- A PRESET write during CNT does not disturb the running count; it takes effect at the next LOAD.
- PRESET = 0 or 1 behaves like COUNT<=1: INT is reached on the first CNT edge.
- One-shot `irq_flag` is cleared only when software re-sets EN and the FSM passes through IDLE. Clearing IM masks `irq` but does not clear the flag.
- Assertion of `reset` mid-count aborts the count; no interrupt is issued.

## Timing
- Reset values: CTRL=0, PRESET=0, COUNT=0, state=IDLE, `irq_flag`=0, `irq`=0, `rdata`=0.
- Writes take effect at the clock edge where `we`=1. `rdata` reflects register contents combinationally in the same cycle, with no read latency.
- Reference point: EN written at edge 0, PRESET=N with N>=2.
  - Edge 1: state = LOAD.
  - Edge 2: COUNT=N, state = CNT.
  - Edge 2+k: COUNT=N-k, until COUNT reaches 1 at edge N+1.
  - Edge N+2: COUNT=0, state = INT, `irq` rises (if IM=1).
  - Edge N+3: state = IDLE.
- Auto-reload:
  - `irq` is high for exactly one cycle (edges N+2 to N+3).
  - Reload occurs at edge N+4 (LOAD) and edge N+5 (COUNT=N).
  - Interrupt period is N+3 cycles.
- One-shot: `irq` stays high from edge N+2 until two edges after software rewrites EN=1 (the edge that writes EN, then the IDLE edge that clears the flag).

## Test plan
- Reset: hold `reset` low, then release.
  -> All registers read 0; `irq`=0.
  -> Asserting `reset` low mid-count returns every register to 0 immediately, without waiting for a clock edge.
- One-shot: PRESET=5, then CTRL=0x9 (EN, one-shot, IM).
  -> COUNT reads 5,4,3,2,1,0.
  -> `irq` rises at edge 7 after the CTRL write and stays high.
  -> CTRL reads 0x8.
- Auto-reload: PRESET=3, CTRL=0xB.
  -> `irq` is a one-cycle pulse every 6 cycles, first at edge 5.
  -> COUNT sequence 3,2,1,0 repeats.
- Byte enables: write PRESET=0xAABBCCDD with `byteen`=1111, then 0x11223344 with `byteen`=0101.
  -> PRESET reads 0xAA22CC44.
  -> Write CTRL=0xFFFFFFFF -> CTRL reads 0xF.
  -> Write to COUNT -> COUNT unchanged.
- Pause and mask:
  - Clear EN mid-count (COUNT=7). -> COUNT holds 7 and state returns to IDLE.
  - Re-enable. -> COUNT reloads from PRESET.
  - One-shot expiry with IM=0. -> `irq` stays 0 while `irq_flag` is set.
  - Set IM=1. -> `irq` rises the next cycle.
- Collision: CPU writes CTRL=0x9 in the same cycle the FSM is in INT (one-shot).
  -> EN stays 1.
  -> FSM returns to IDLE, then LOAD, and `irq` clears.
